// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_START   = 3'd2,
    ST_DATA    = 3'd3,
    ST_PAR     = 3'd4,
    ST_STOP    = 3'd5
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with registered storage; full/empty from the extra pointer MSB.
module uart_sync_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]  mem [2**AW];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed framing FSM, LSB-first, optional parity, 1/2 stop bits.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCKFRQ       = 48_000_000,
  parameter int BAUDRATE       = 12_000_000,
  parameter int FIFO_AW        = 4,
  parameter int STOP_BITS      = 1,
  parameter int PARITY         = 0,
  parameter int STARTUP_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_valid,
  input  logic [7:0]         tx_byte,
  output logic               tx_ready,
  output logic               tx,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy
);

  localparam int CPB = CLOCKFRQ / BAUDRATE;
  localparam int TW  = clog2(CPB);
  localparam int SW  = clog2(STARTUP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST    = TW'(CPB - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(STARTUP_CYCLES - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if ((CLOCKFRQ % BAUDRATE) != 0 || CPB < 2) begin : g_bad_baud
    $error("uart_tx_buffered: CLOCKFRQ/BAUDRATE must be an integer >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
    $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
  end

  uart_state_e   state, next_state;
  logic [TW-1:0] timer;
  logic [SW-1:0] startup_cnt;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          tx_q, busy_q, tx_d, busy_d;
  logic          pop, bit_end;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rd_data;

  assign bit_end = (timer == T_LAST);

  uart_sync_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid && !fifo_full),
    .wr_data (tx_byte),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_STARTUP;
    else      state <= next_state;
  end

  // Leaving STARTUP with data queued pops directly so the hold is exactly STARTUP_CYCLES.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      ST_STARTUP: if (startup_cnt == S_LAST) begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_START;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        next_state = ST_START;
      end
      ST_START: if (bit_end) next_state = ST_DATA;
      ST_DATA:  if (bit_end && bit_cnt == 3'd7)
        next_state = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:   if (bit_end) next_state = ST_STOP;
      ST_STOP:  if (bit_end && stop_cnt == STOP_LAST) begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_START;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default:  next_state = ST_STARTUP;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state)
      ST_IDLE:  busy_d = !fifo_empty;
      ST_START: tx_d   = 1'b0;
      ST_DATA:  tx_d   = shift[0];
      ST_PAR:   tx_d   = par_bit;
      default:  tx_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer       <= '0;
      startup_cnt <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shift       <= '0;
      par_bit     <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b1;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      if (state == ST_STARTUP && startup_cnt != S_LAST)
        startup_cnt <= startup_cnt + SW'(1);
      if (state == ST_START || state == ST_DATA || state == ST_PAR || state == ST_STOP)
        timer <= bit_end ? '0 : timer + TW'(1);
      else
        timer <= '0;
      if (state != ST_DATA)
        bit_cnt <= '0;
      else if (bit_end)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == ST_STOP && bit_end)
        stop_cnt <= (stop_cnt == STOP_LAST) ? 1'b0 : ~stop_cnt;
      if (pop) begin
        shift   <= fifo_rd_data;
        par_bit <= (^fifo_rd_data) ^ (PARITY == PAR_ODD);
      end else if (state == ST_DATA && bit_end) begin
        shift <= shift >> 1;
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: scoreboard-decoded line plus per-scenario timing checks.
module tb_uart_tx_buffered;

  localparam int CPB     = 4;
  localparam int STARTUP = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v0 = 1'b0, v_pe = 1'b0, v_po = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  logic       rdy0, tx0, busy0;
  logic [4:0] lvl0;
  logic       rdy_pe, tx_pe, busy_pe;
  logic [4:0] lvl_pe;
  logic       rdy_po, tx_po, busy_po;
  logic [4:0] lvl_po;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLOCKFRQ(48_000_000), .BAUDRATE(12_000_000)) dut (
    .clk(clk), .rst(rst), .tx_valid(v0), .tx_byte(tx_byte),
    .tx_ready(rdy0), .tx(tx0), .fifo_level(lvl0), .busy(busy0)
  );

  uart_tx_buffered #(.PARITY(2), .STOP_BITS(2), .STARTUP_CYCLES(16)) dut_pe (
    .clk(clk), .rst(rst), .tx_valid(v_pe), .tx_byte(tx_byte),
    .tx_ready(rdy_pe), .tx(tx_pe), .fifo_level(lvl_pe), .busy(busy_pe)
  );

  uart_tx_buffered #(.PARITY(1), .STARTUP_CYCLES(16)) dut_po (
    .clk(clk), .rst(rst), .tx_valid(v_po), .tx_byte(tx_byte),
    .tx_ready(rdy_po), .tx(tx_po), .fifo_level(lvl_po), .busy(busy_po)
  );

  function automatic logic frame_bit(input logic [7:0] b, input int par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (par != 0 && idx == 9) return (par == 2) ? ^b : ~(^b);
    return 1'b1;
  endfunction

  task automatic monitor();
    int         pos;
    int         k;
    logic [7:0] d;
    logic [7:0] exp;
    pos = -1;
    d   = '0;
    forever begin
      @(negedge clk);
      if (!rst) pos = -1;
      else if (pos < 0) begin
        if (tx0 === 1'b0) pos = 0;
      end else pos++;
      if (pos >= 0 && (pos % CPB) == CPB/2) begin
        k = pos / CPB;
        if (k == 0) begin
          checks++;
          if (tx0 !== 1'b0) begin
            errors++;
            $display("FAIL mon_start: tx %b, required 0", tx0);
          end
        end else if (k <= 8) begin
          d[k-1] = tx0;
        end else begin
          checks++;
          if (tx0 !== 1'b1) begin
            errors++;
            $display("FAIL mon_stop: tx %b, required 1", tx0);
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected_frame: got %02h, required no frame", d);
          end else begin
            exp = sb.pop_front();
            if (d !== exp) begin
              errors++;
              $display("FAIL mon_byte: got %02h, required %02h", d, exp);
            end
          end
          pos = -1;
        end
      end
    end
  endtask

  task automatic send_main(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    tx_byte = b;
    v0      = 1'b1;
    while (rdy0 !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: tx_ready %b after %0d cycles, required 1", rdy0, n);
      v0 = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(b);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy0 !== 1'b0 || lvl0 !== 5'd0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL wait_idle: busy %b level %0d after %0d cycles, required idle", busy0, lvl0, n);
    end
  endtask

  task automatic test_reset();
    #22;
    checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b, required 1", tx0); end
    checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b, required 1", rdy0); end
    checks++; if (lvl0 !== 5'd0)  begin errors++; $display("FAIL reset_level: got %0d, required 0", lvl0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, required 1", busy0); end
  endtask

  task automatic test_startup();
    int hi, busy_drop;
    bit seen_low;
    @(negedge clk);
    rst     = 1'b1;
    tx_byte = 8'h00;
    v0      = 1'b1;
    @(posedge clk);
    sb.push_back(8'h00);
    hi = 0; busy_drop = 0; seen_low = 1'b0;
    for (int k = 1; k <= STARTUP + 50 && !seen_low; k++) begin
      @(negedge clk);
      if (k == 1) v0 = 1'b0;
      if (tx0 === 1'b0) seen_low = 1'b1;
      else hi++;
      if (busy0 !== 1'b1) busy_drop++;
    end
    checks++;
    if (hi != STARTUP || !seen_low) begin
      errors++;
      $display("FAIL startup_hold: high for %0d cycles (low seen %b), required %0d", hi, seen_low, STARTUP);
    end
    checks++;
    if (busy_drop != 0) begin
      errors++;
      $display("FAIL startup_busy: busy low in %0d cycles, required 0", busy_drop);
    end
  endtask

  task automatic test_single();
    logic exp;
    wait_idle();
    tx_byte = 8'hAA;
    repeat (3) @(negedge clk);
    checks++;
    if (lvl0 !== 5'd0) begin errors++; $display("FAIL ignore_invalid: level %0d, required 0", lvl0); end
    send_main(8'h55);
    for (int j = 0; j <= 42; j++) begin
      @(negedge clk);
      if (j == 0) v0 = 1'b0;
      exp = (j < 2 || j >= 42) ? 1'b1 : frame_bit(8'h55, 0, (j - 2) / CPB);
      checks++;
      if (tx0 !== exp) begin errors++; $display("FAIL single_line[%0d]: tx %b, required %b", j, tx0, exp); end
      if (j == 41) begin
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b, required 1", busy0); end
      end
      if (j == 42) begin
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", busy0); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t2, t1, t0, tb;
    wait_idle();
    send_main(8'h3C);
    send_main(8'hA0);
    send_main(8'h0F);
    send_main(8'hFF);
    @(negedge clk);
    v0 = 1'b0;
    checks++;
    if (lvl0 !== 5'd3) begin errors++; $display("FAIL b2b_level: got %0d, required 3", lvl0); end
    t2 = -1; t1 = -1; t0 = -1; tb = -1;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      if (lvl0 === 5'd2 && t2 < 0) t2 = c;
      if (lvl0 === 5'd1 && t1 < 0) t1 = c;
      if (lvl0 === 5'd0 && t0 < 0) t0 = c;
      if (busy0 === 1'b0 && tb < 0) tb = c;
    end
    checks++;
    if (t2 < 0 || t1 - t2 != 40) begin errors++; $display("FAIL b2b_pop2: gap %0d, required 40", t1 - t2); end
    checks++;
    if (t2 < 0 || t0 - t2 != 80) begin errors++; $display("FAIL b2b_pop3: gap %0d, required 80", t0 - t2); end
    checks++;
    if (t2 < 0 || tb - t2 != 121) begin errors++; $display("FAIL b2b_span: %0d cycles, required 121", tb - t2); end
  endtask

  task automatic test_mid_reset();
    int lows;
    wait_idle();
    send_main(8'h00);
    @(negedge clk);
    v0 = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (tx0 !== 1'b0) begin errors++; $display("FAIL midrst_pre: tx %b, required 0", tx0); end
    #2 rst = 1'b0;
    #1;
    checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL midrst_tx: got %b, required 1", tx0); end
    checks++; if (lvl0 !== 5'd0)  begin errors++; $display("FAIL midrst_level: got %0d, required 0", lvl0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b, required 1", busy0); end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
    lows = 0;
    repeat (STARTUP + 100) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
    end
    checks++; if (lows != 0)      begin errors++; $display("FAIL midrst_residual: %0d low cycles, required 0", lows); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b, required 0", busy0); end
  endtask

  task automatic test_fifo_full();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) send_main(8'(i * 37 + 5));
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0)  begin errors++; $display("FAIL full_ready: got %b, required 0", rdy0); end
    checks++; if (lvl0 !== 5'd16) begin errors++; $display("FAIL full_level: got %0d, required 16", lvl0); end
    send_main(8'(16 * 37 + 5));
    @(negedge clk);
    v0 = 1'b0;
    checks++;
    if (lvl0 !== 5'd16) begin errors++; $display("FAIL full_refill: level %0d, required 16", lvl0); end
    wait_idle();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL full_drain: %0d bytes pending, required 0", sb.size()); end
  endtask

  task automatic test_parity();
    logic exp_pe, exp_po;
    @(negedge clk);
    tx_byte = 8'h07;
    v_pe    = 1'b1;
    v_po    = 1'b1;
    checks++;
    if (rdy_pe !== 1'b1 || rdy_po !== 1'b1) begin
      errors++; $display("FAIL par_ready: got %b%b, required 11", rdy_pe, rdy_po);
    end
    @(posedge clk);
    for (int j = 0; j <= 51; j++) begin
      @(negedge clk);
      if (j == 0) begin v_pe = 1'b0; v_po = 1'b0; end
      exp_pe = (j < 2 || j >= 50) ? 1'b1 : frame_bit(8'h07, 2, (j - 2) / CPB);
      exp_po = (j < 2 || j >= 46) ? 1'b1 : frame_bit(8'h07, 1, (j - 2) / CPB);
      checks++;
      if (tx_pe !== exp_pe) begin errors++; $display("FAIL even_line[%0d]: tx %b, required %b", j, tx_pe, exp_pe); end
      checks++;
      if (tx_po !== exp_po) begin errors++; $display("FAIL odd_line[%0d]: tx %b, required %b", j, tx_po, exp_po); end
      if (j == 49 || j == 50) begin
        checks++;
        if (busy_pe !== (j == 49)) begin errors++; $display("FAIL even_busy[%0d]: got %b, required %b", j, busy_pe, j == 49); end
      end
      if (j == 45 || j == 46) begin
        checks++;
        if (busy_po !== (j == 45)) begin errors++; $display("FAIL odd_busy[%0d]: got %b, required %b", j, busy_po, j == 45); end
      end
    end
    checks++;
    if (lvl_pe !== 5'd0 || lvl_po !== 5'd0) begin
      errors++; $display("FAIL par_level: got %0d/%0d, required 0/0", lvl_pe, lvl_po);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_startup();
    test_single();
    test_back_to_back();
    test_mid_reset();
    test_fifo_full();
    test_parity();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d bytes pending, required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
